// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
// Holds the FSM state encoding, the default operand width, the ALU opcodes served by
// this path, and the signed-overflow helper used by the flag logic.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Explicit encoding; code 2'd3 is unreachable and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ALU opcodes routed to this block: SUB (borrow_in=0), SBB (borrow_in=carry flag),
    // CMP (SUB with the difference discarded by the consumer).
    typedef enum logic [3:0] {
        ALU_OP_SUB = 4'h2,
        ALU_OP_SBB = 4'h3,
        ALU_OP_CMP = 4'h7
    } alu_op_t;

    // Signed overflow of a - b: operand signs differ and the result sign differs from a.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle of the bit-serial subtractor
// Signals:
//   start_valid/start_ready  operand handshake carrying a, b, borrow_in
//   res_valid/res_ready      result handshake carrying diff, borrow_out, overflow, zero
// Modports:
//   master  producer of operands and consumer of results
//   slave   the subtractor itself
interface serial_subtractor_if #(
    parameter int WIDTH = 32
);
    import serial_subtractor_pkg::*;

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start_valid, a, b, borrow_in, res_ready,
        input  start_ready, res_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  start_valid, a, b, borrow_in, res_ready,
        output start_ready, res_valid, diff, borrow_out, overflow, zero
    );

endinterface

// File: rtl/serial_subtractor_subtractor_1b.sv
// rtl/serial_subtractor_subtractor_1b.sv - 1-bit full subtractor cell
// Ports:
//   a, b        minuend and subtrahend bits
//   borrow_in   borrow from the less significant bit
//   diff        a - b - borrow_in, bit result
//   borrow_out  borrow into the more significant bit
module subtractor_1b
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    // Borrow when b exceeds a, or when they are equal and a borrow is already pending.
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle bit-serial subtractor, D = A - B - borrow_in, LSB first
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_subtractor_if.slave: operand handshake (start_*, a, b, borrow_in) and
//          result handshake (res_*, diff, borrow_out, overflow, zero)
// One operand bit pair is consumed per RUN cycle; the difference is assembled in a shift
// register filled from the MSB so it is right-aligned after WIDTH cycles.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             bin_q, bin_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q, res_valid_d;

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] diff_next;

    subtractor_1b u_cell (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .borrow_in  (bin_q),
        .diff       (cell_diff),
        .borrow_out (cell_borrow)
    );

    // Difference register after this cycle's bit lands at the MSB.
    assign diff_next = {cell_diff, diff_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        diff_sh_d     = diff_sh_q;
        bin_d         = bin_q;
        a_msb_d       = a_msb_q;
        b_msb_d       = b_msb_q;
        borrow_out_d  = borrow_out_q;
        overflow_d    = overflow_q;
        zero_d        = zero_q;
        start_ready_d = start_ready_q;
        res_valid_d   = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                start_ready_d = 1'b1;
                res_valid_d   = 1'b0;
                if (bus.start_valid) begin
                    a_sh_d        = bus.a;
                    b_sh_d        = bus.b;
                    bin_d         = bus.borrow_in;
                    a_msb_d       = bus.a[WIDTH-1];
                    b_msb_d       = bus.b[WIDTH-1];
                    cnt_d         = '0;
                    state_d       = ST_RUN;
                    start_ready_d = 1'b0;
                end
            end

            ST_RUN: begin
                start_ready_d = 1'b0;
                res_valid_d   = 1'b0;
                a_sh_d        = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d        = {1'b0, b_sh_q[WIDTH-1:1]};
                diff_sh_d     = diff_next;
                bin_d         = cell_borrow;
                if (cnt_q == LAST_BIT) begin
                    // Last bit: the counter parks here rather than wrapping.
                    state_d      = ST_DONE;
                    res_valid_d  = 1'b1;
                    borrow_out_d = cell_borrow;
                    overflow_d   = signed_ovf(a_msb_q, b_msb_q, cell_diff);
                    zero_d       = (diff_next == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                start_ready_d = 1'b0;
                res_valid_d   = 1'b1;
                if (bus.res_ready) begin
                    // Back to IDLE only; a start offered now is taken on the next cycle.
                    state_d       = ST_IDLE;
                    res_valid_d   = 1'b0;
                    start_ready_d = 1'b1;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                start_ready_d = 1'b1;
                res_valid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            diff_sh_q     <= '0;
            bin_q         <= 1'b0;
            a_msb_q       <= 1'b0;
            b_msb_q       <= 1'b0;
            borrow_out_q  <= 1'b0;
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            diff_sh_q     <= diff_sh_d;
            bin_q         <= bin_d;
            a_msb_q       <= a_msb_d;
            b_msb_q       <= b_msb_d;
            borrow_out_q  <= borrow_out_d;
            overflow_q    <= overflow_d;
            zero_q        <= zero_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.diff        = diff_sh_q;
    assign bus.borrow_out  = borrow_out_q;
    assign bus.overflow    = overflow_q;
    assign bus.zero        = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8, 32 and 2
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    typedef struct {
        logic [63:0] diff;
        logic        bo;
        logic        ov;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  i8 ();
    serial_subtractor_if #(.WIDTH(32)) i32 ();
    serial_subtractor_if #(.WIDTH(2))  i2 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_subtractor #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32));
    serial_subtractor #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(i2));

    exp_t q8[$];
    exp_t q32[$];
    exp_t q2[$];
    exp_t last8;

    // Reference: {borrow, diff} = a - b - bin over w bits.
    function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic bin);
        logic [63:0] mask;
        logic [64:0] full;
        exp_t        e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        full   = {1'b0, a & mask} - {1'b0, b & mask} - 65'(bin);
        e.diff = full[63:0] & mask;
        e.bo   = full[w];
        e.ov   = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
        e.z    = (e.diff == 64'd0);
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch8(logic [7:0] a, logic [7:0] b, logic bin);
        int n = 0;
        while (!i8.start_ready && n < 50) begin tick(); n++; end
        chk("start_ready8", i8.start_ready, 1);
        i8.a = a; i8.b = b; i8.borrow_in = bin; i8.start_valid = 1'b1;
        q8.push_back(model(8, a, b, bin));
        tick();
        i8.start_valid = 1'b0;
        i8.a = 8'($urandom); i8.b = 8'($urandom); i8.borrow_in = 1'($urandom);
        chk("busy8", i8.start_ready, 0);
    endtask

    task automatic await8();
        int n = 0;
        while (!i8.res_valid && n < 100) begin tick(); n++; end
        chk("latency8", n, 8);
        chk("sb8_depth", q8.size(), 1);
        if (q8.size() > 0) begin
            last8 = q8.pop_front();
            chk("diff8", i8.diff, last8.diff);
            chk("borrow8", i8.borrow_out, last8.bo);
            chk("ovf8", i8.overflow, last8.ov);
            chk("zero8", i8.zero, last8.z);
        end
    endtask

    task automatic release8();
        i8.res_ready = 1'b1;
        tick();
        i8.res_ready = 1'b0;
        chk("res_valid_drop8", i8.res_valid, 0);
        chk("ready_back8", i8.start_ready, 1);
    endtask

    task automatic op8(logic [7:0] a, logic [7:0] b, logic bin);
        launch8(a, b, bin);
        await8();
        release8();
    endtask

    task automatic op32(logic [31:0] a, logic [31:0] b, logic bin);
        exp_t e;
        int   n = 0;
        while (!i32.start_ready && n < 50) begin tick(); n++; end
        i32.a = a; i32.b = b; i32.borrow_in = bin; i32.start_valid = 1'b1;
        q32.push_back(model(32, a, b, bin));
        tick();
        i32.start_valid = 1'b0;
        n = 0;
        while (!i32.res_valid && n < 100) begin tick(); n++; end
        chk("latency32", n, 32);
        if (q32.size() > 0) begin
            e = q32.pop_front();
            chk("diff32", i32.diff, e.diff);
            chk("borrow32", i32.borrow_out, e.bo);
            chk("ovf32", i32.overflow, e.ov);
            chk("zero32", i32.zero, e.z);
        end
        repeat ($urandom_range(0, 2)) tick();
        i32.res_ready = 1'b1;
        tick();
        i32.res_ready = 1'b0;
    endtask

    task automatic op2(logic [1:0] a, logic [1:0] b, logic bin);
        exp_t e;
        int   n = 0;
        while (!i2.start_ready && n < 50) begin tick(); n++; end
        i2.a = a; i2.b = b; i2.borrow_in = bin; i2.start_valid = 1'b1;
        q2.push_back(model(2, a, b, bin));
        tick();
        i2.start_valid = 1'b0;
        n = 0;
        while (!i2.res_valid && n < 100) begin tick(); n++; end
        chk("latency2", n, 2);
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("diff2", i2.diff, e.diff);
            chk("borrow2", i2.borrow_out, e.bo);
            chk("ovf2", i2.overflow, e.ov);
            chk("zero2", i2.zero, e.z);
        end
        repeat ($urandom_range(0, 1)) tick();
        i2.res_ready = 1'b1;
        tick();
        i2.res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i8.start_valid = 0; i8.a = 0; i8.b = 0; i8.borrow_in = 0; i8.res_ready = 0;
        i32.start_valid = 0; i32.a = 0; i32.b = 0; i32.borrow_in = 0; i32.res_ready = 0;
        i2.start_valid = 0; i2.a = 0; i2.b = 0; i2.borrow_in = 0; i2.res_ready = 0;

        // Reset and idle outputs
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_start_ready", i8.start_ready, 1);
        chk("rst_res_valid", i8.res_valid, 0);
        chk("rst_diff", i8.diff, 0);
        chk("rst_borrow", i8.borrow_out, 0);
        chk("rst_ovf", i8.overflow, 0);
        chk("rst_zero", i8.zero, 0);

        // Directed vectors
        op8(8'h5A, 8'h23, 1'b0);
        chk("dir_5a_diff", i8.diff, 8'h37);
        op8(8'h10, 8'h20, 1'b1);
        chk("dir_10_diff", i8.diff, 8'hEF);
        chk("dir_10_borrow", i8.borrow_out, 1);
        op8(8'h3C, 8'h3C, 1'b0);
        chk("dir_3c_zero", i8.zero, 1);
        op8(8'h80, 8'h01, 1'b0);
        chk("dir_80_ovf", i8.overflow, 1);
        chk("dir_80_diff", i8.diff, 8'h7F);
        op8(8'h7F, 8'hFF, 1'b0);
        chk("dir_7f_diff", i8.diff, 8'h80);
        chk("dir_7f_borrow", i8.borrow_out, 1);
        chk("dir_7f_ovf", i8.overflow, 1);

        // Hold in DONE with start pulses, then release together with a start
        launch8(8'hC3, 8'h3C, 1'b1);
        await8();
        for (int k = 0; k < 5; k++) begin
            i8.start_valid = k[0];
            i8.a = 8'($urandom); i8.b = 8'($urandom);
            tick();
            chk("hold_valid", i8.res_valid, 1);
            chk("hold_ready", i8.start_ready, 0);
            chk("hold_diff", i8.diff, last8.diff);
            chk("hold_borrow", i8.borrow_out, last8.bo);
            chk("hold_ovf", i8.overflow, last8.ov);
            chk("hold_zero", i8.zero, last8.z);
        end
        i8.start_valid = 1'b1; i8.a = 8'h01; i8.b = 8'h02; i8.borrow_in = 1'b0;
        i8.res_ready = 1'b1;
        tick();
        i8.res_ready = 1'b0;
        chk("release_valid", i8.res_valid, 0);
        chk("release_not_taken", i8.start_ready, 1);
        q8.push_back(model(8, 8'h01, 8'h02, 1'b0));
        tick();
        i8.start_valid = 1'b0;
        chk("taken_from_idle", i8.start_ready, 0);
        await8();
        chk("release_op_diff", i8.diff, 8'hFF);
        release8();

        // Reset in the middle of RUN aborts the op
        launch8(8'hA5, 8'h0F, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", i8.res_valid, 0);
        chk("midrst_diff", i8.diff, 0);
        chk("midrst_borrow", i8.borrow_out, 0);
        chk("midrst_ovf", i8.overflow, 0);
        chk("midrst_zero", i8.zero, 0);
        q8.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready", i8.start_ready, 1);
        repeat (10) tick();
        chk("midrst_no_result", i8.res_valid, 0);
        op8(8'h00, 8'h00, 1'b1);
        chk("after_rst_diff", i8.diff, 8'hFF);

        // Random operands at each width
        for (int i = 0; i < 300; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 1000; i++) op32($urandom, $urandom, 1'($urandom));
        for (int i = 0; i < 2000; i++) op2(2'($urandom), 2'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
